// File: rtl/serial_hex_cmp_ctrl.sv
// Serial nibble-at-a-time magnitude comparator (E/L/G over NIBBLES nibbles).
// Define HEXCMP_EARLY_EXIT_EN for MSB-first order with stop on first unequal nibble.

module hexcmp_slice (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_e,
  input  logic       i_l,
  input  logic       i_g,
  output logic       o_e,
  output logic       o_l,
  output logic       o_g
);

  always_comb begin
    o_e = i_e;
    o_l = i_l;
    o_g = i_g;
    if (i_a > i_b) begin
      o_e = 1'b0;
      o_l = 1'b0;
      o_g = 1'b1;
    end else if (i_a < i_b) begin
      o_e = 1'b0;
      o_l = 1'b1;
      o_g = 1'b0;
    end
  end

endmodule

module serial_hex_cmp_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] a_in,
  input  logic [4*NIBBLES-1:0] b_in,
  output logic                 ready,
  output logic                 done,
  output logic                 E,
  output logic                 L,
  output logic                 G
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = $clog2(NIBBLES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CW-1:0] IDX_LO = '0;
  localparam logic [CW-1:0] IDX_HI = CW'(NIBBLES - 1);

`ifdef HEXCMP_EARLY_EXIT_EN
  localparam logic [CW-1:0] IDX_FIRST = IDX_HI;
  localparam logic [CW-1:0] IDX_END   = IDX_LO;
`else
  localparam logic [CW-1:0] IDX_FIRST = IDX_LO;
  localparam logic [CW-1:0] IDX_END   = IDX_HI;
`endif

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic          r_e;
  logic          r_l;
  logic          r_g;
  logic          r_oe;
  logic          r_ol;
  logic          r_og;

  logic [3:0]    w_an;
  logic [3:0]    w_bn;
  logic          w_e;
  logic          w_l;
  logic          w_g;
  logic          w_last;
  logic          w_fin;

  assign w_an = r_a[{r_cnt, 2'b00} +: 4];
  assign w_bn = r_b[{r_cnt, 2'b00} +: 4];

  hexcmp_slice u_slice (
    .i_a (w_an),
    .i_b (w_bn),
    .i_e (r_e),
    .i_l (r_l),
    .i_g (r_g),
    .o_e (w_e),
    .o_l (w_l),
    .o_g (w_g)
  );

  assign w_last = (r_cnt == IDX_END);

`ifdef HEXCMP_EARLY_EXIT_EN
  // Scanning from the MSB, the first unequal nibble decides everything.
  assign w_fin = w_last | (w_an != w_bn);
`else
  assign w_fin = w_last;
`endif

  assign ready = (r_state == S_IDLE);
  assign done  = (r_state == S_DONE);
  assign E     = r_oe;
  assign L     = r_ol;
  assign G     = r_og;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_e     <= 1'b1;
      r_l     <= 1'b0;
      r_g     <= 1'b0;
      r_oe    <= 1'b0;
      r_ol    <= 1'b0;
      r_og    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a_in;
            r_b     <= b_in;
            r_e     <= 1'b1;
            r_l     <= 1'b0;
            r_g     <= 1'b0;
            r_cnt   <= IDX_FIRST;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_e <= w_e;
          r_l <= w_l;
          r_g <= w_g;
          if (w_fin) begin
            r_oe    <= w_e;
            r_ol    <= w_l;
            r_og    <= w_g;
            r_state <= S_DONE;
          end else begin
`ifdef HEXCMP_EARLY_EXIT_EN
            r_cnt <= r_cnt - CW'(1);
`else
            r_cnt <= r_cnt + CW'(1);
`endif
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_hex_cmp_ctrl.sv
// Directed self-checking bench for serial_hex_cmp_ctrl (NIBBLES=4).
// Expected latency follows HEXCMP_EARLY_EXIT_EN when it is defined.

module tb_serial_hex_cmp_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic        ready;
  logic        done;
  logic        E;
  logic        L;
  logic        G;

  int n_run;
  int n_fail;

  localparam logic [2:0] EQ = 3'b100;
  localparam logic [2:0] LT = 3'b010;
  localparam logic [2:0] GT = 3'b001;

  serial_hex_cmp_ctrl #(.NIBBLES(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a_in  (a_in),
    .b_in  (b_in),
    .ready (ready),
    .done  (done),
    .E     (E),
    .L     (L),
    .G     (G)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // mode 0: quiet, 1: hold start with na/nb, 2: random operands
  task automatic do_cmp(input string tag,
                        input logic [15:0] a,
                        input logic [15:0] b,
                        input logic [2:0] elg,
                        input int lat_lsb,
                        input int lat_ee,
                        input int mode,
                        input logic [15:0] na,
                        input logic [15:0] nb);
    int lat;
    int exp_lat;
    bit seen;
`ifdef HEXCMP_EARLY_EXIT_EN
    exp_lat = lat_ee;
`else
    exp_lat = lat_lsb;
`endif
    check({tag, "_rdy_idle"}, 32'(ready), 32'd1);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    @(posedge clk); #1;
    check({tag, "_rdy_run"}, 32'(ready), 32'd0);
    start = 1'b0;
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (mode == 1) begin
        start = 1'b1;
        a_in  = na;
        b_in  = nb;
      end else if (mode == 2) begin
        a_in = 16'($urandom);
        b_in = 16'($urandom);
      end
      @(posedge clk); #1;
      lat++;
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_elg"}, 32'({E, L, G}), 32'(elg));
    check({tag, "_rdy_done"}, 32'(ready), 32'd0);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_rdy_back"}, 32'(ready), 32'd1);
    check({tag, "_elg_hold"}, 32'({E, L, G}), 32'(elg));
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    rst    = 1'b1;
    start  = 1'b0;
    a_in   = '0;
    b_in   = '0;
    #2;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_elg", 32'({E, L, G}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    do_cmp("eq", 16'h1234, 16'h1234, EQ, 4, 4, 0, 16'h0, 16'h0);
    do_cmp("gt_lsb", 16'h1235, 16'h1234, GT, 4, 4, 0, 16'h0, 16'h0);
    do_cmp("lt_msb", 16'h0FFF, 16'h1000, LT, 4, 1, 0, 16'h0, 16'h0);
    do_cmp("gt_msb", 16'h8000, 16'h7FFF, GT, 4, 1, 0, 16'h0, 16'h0);
    do_cmp("gt_max", 16'hFFFF, 16'h0000, GT, 4, 1, 0, 16'h0, 16'h0);
    do_cmp("lt_max", 16'h0000, 16'hFFFF, LT, 4, 1, 0, 16'h0, 16'h0);
    do_cmp("lt_n2", 16'h5A5A, 16'h5B5A, LT, 4, 2, 0, 16'h0, 16'h0);

    do_cmp("ign", 16'h0001, 16'h0000, GT, 4, 4, 1, 16'h0000, 16'h0001);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("ign_no_done", 32'(done), 32'd0);
    end
    do_cmp("ign_next", 16'h0000, 16'h0001, LT, 4, 4, 0, 16'h0, 16'h0);

    do_cmp("scramble", 16'hABCD, 16'hABC0, GT, 4, 4, 2, 16'h0, 16'h0);

    a_in  = 16'h0001;
    b_in  = 16'h0000;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("arst_ready", 32'(ready), 32'd1);
    check("arst_done", 32'(done), 32'd0);
    check("arst_elg", 32'({E, L, G}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("arst_no_done", 32'(done), 32'd0);
    end
    do_cmp("post_rst", 16'h1234, 16'h1233, GT, 4, 4, 0, 16'h0, 16'h0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_hex_cmp_ctrl.md
# serial_hex_cmp_ctrl

Sequencer that time-shares a single 4-bit magnitude-compare slice across all nibbles of two wide operands. It produces the same equal/less/greater result as the parallel 16-bit cascade, using one slice and NIBBLES clock cycles instead of four slice instances. It sits between an operand producer, which uses a start/ready handshake, and any consumer of the E/L/G flags, which watches a one-cycle done pulse. The nibble compare slice is internal to the block.

## Interface
- NIBBLES, 4, number of 4-bit nibbles per operand; legal range is 2 or more.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  request a compare; sampled only while ready=1.
- a_in  in  4*NIBBLES  operand A, unsigned; nibble k is a_in[4k+3:4k].
- b_in  in  4*NIBBLES  operand B, unsigned, same packing as A.
- ready  out  1  high in IDLE; block can accept start.
- done  out  1  one-cycle pulse; E/L/G are valid and new.
- E  out  1  A == B.
- L  out  1  A < B.
- G  out  1  A > B.

## Operation
- States:
  - IDLE: ready=1.
  - RUN: ready=0. Processes one nibble per cycle.
  - DONE: ready=0, done=1. Lasts exactly one cycle, then returns to IDLE.
- IDLE with start=1:
  - Latch a_in and b_in into internal registers.
  - Initialise the running flags to e=1, l=0, g=0.
  - Set the nibble counter to its first index, then enter RUN.
- RUN, each cycle, compare the selected latched nibble pair:
  - a_n > b_n: flags become e=0, l=0, g=1.
  - a_n < b_n: flags become e=0, l=1, g=0.
  - a_n == b_n: flags keep their previous values (cascade pass-through).
- Default order is least-significant nibble first (index 0 up to NIBBLES-1). A higher nibble therefore overrides any lower result, exactly like the parallel cascade.
- After the last nibble's edge:
  - E/L/G registers load the final flags.
  - State moves to DONE.
- E/L/G hold their value from DONE onward until the next completion. Intermediate flags are never visible on the outputs.
- Invariant: after the first completion, exactly one of E/L/G is 1.
- start while ready=0 (RUN or DONE) is ignored and is not queued.
- a_in/b_in changes after the capture edge have no effect on the result.

## Timing
- Reset values: state=IDLE, ready=1, done=0, E=0, L=0, G=0. Counter and latched operands are cleared.
- rst asserted mid-RUN or in DONE: block immediately returns to IDLE with the reset values. No done pulse is produced for the aborted compare.
- Latency without early exit:
  - Capture edge is edge 0; edges 1..NIBBLES process nibbles.
  - done=1 in the cycle after edge NIBBLES, i.e. NIBBLES cycles after capture (4 by default).
  - ready returns high one cycle later.
  - Back-to-back throughput: one compare per NIBBLES+2 cycles.
- The counter does not wrap. It is used only within one RUN episode and is reset on entry to RUN.
- done and ready are never high in the same cycle.

## Configuration
- HEXCMP_EARLY_EXIT_EN, defined:
  - Nibbles are processed most-significant first (NIBBLES-1 down to 0).
  - RUN ends on the first unequal nibble; flags are set by that nibble alone.
  - Latency is k+1 cycles to done, where k is the zero-based position of the first differing nibble counted from the MSB.
  - Equal operands take the full NIBBLES cycles.
  - E/L/G results are identical to the undefined case.
- HEXCMP_EARLY_EXIT_EN undefined: fixed LSB-first cascade with a constant NIBBLES-cycle latency, as described above.

## Test plan
- Reset, then A=0x1234, B=0x1234, start: E=1, L=0, G=0. done pulses 4 cycles after capture for 1 cycle. ready=0 from the capture edge until the cycle after done.
- A=0x1235, B=0x1234: G=1. A=0x0FFF, B=0x1000: L=1, showing the MS nibble overriding lower "greater" results.
- A=0x8000, B=0x7FFF:
  - G=1 in both builds.
  - done comes 1 cycle after capture with HEXCMP_EARLY_EXIT_EN defined.
  - done comes 4 cycles after capture without it.
- start with A=0x0001, B=0x0000, then start again with A=0x0000, B=0x0001 while in RUN: second start ignored. Result is G=1 with a single done pulse. The next accepted start yields L=1.
- Change a_in/b_in every cycle during RUN: result reflects only the values captured at start.
- Assert rst on the second RUN cycle: outputs go to the reset values asynchronously with ready=1, no done pulse follows, and the next compare completes normally.
